// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: shares the core's single Sysbus master port between the
// instruction fetch port (0) and the data/MEM port (1).
//
// Each transaction moves one 64-byte line:
//   - a read returns BEATS response beats;
//   - a write sends BEATS data beats.
// Only one transaction is in flight at a time.
//
// Ports:
//   clk, reset_n                    core clock, asynchronous active-low reset
//   f_req_*                         fetch line-read request and handshake
//   f_resp_*                        fetch response beats
//   d_req_*                         data line read/write request and handshake
//   d_wdata*                        data write-beat stream
//   d_resp_*                        data read response beats
//   bus_req*                        Sysbus request channel
//   bus_resp*                       Sysbus response channel
//   err_sticky                      protocol error seen; cleared only by reset
//
// Build option:
//   ARB_DATA_PRIORITY_EN            when defined, the data port always wins a
//                                   tie; otherwise ties are round-robin.

module sysbus_arbiter #(
  parameter int unsigned BEATS = 8,
  parameter int unsigned TAG_W = 13
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             f_req_valid,
  input  logic [63:0]      f_req_addr,
  output logic             f_req_ready,
  output logic             f_resp_valid,
  output logic [63:0]      f_resp_data,
  input  logic             d_req_valid,
  input  logic             d_req_write,
  input  logic [63:0]      d_req_addr,
  output logic             d_req_ready,
  input  logic [63:0]      d_wdata,
  input  logic             d_wdata_valid,
  output logic             d_wdata_ready,
  output logic             d_resp_valid,
  output logic [63:0]      d_resp_data,
  output logic             bus_reqcyc,
  output logic [63:0]      bus_req,
  output logic [TAG_W-1:0] bus_reqtag,
  input  logic             bus_reqack,
  input  logic             bus_respcyc,
  input  logic [63:0]      bus_resp,
  input  logic [TAG_W-1:0] bus_resptag,
  output logic             bus_respack,
  output logic             err_sticky
);

  localparam int unsigned CntW       = $clog2(BEATS) + 1;
  localparam logic [3:0]  TypeMemory = 4'd1;

  typedef enum logic [1:0] {StIdle, StReq, StWdata, StResp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
  logic            last_grant_q, last_grant_d;  // 0 = fetch, 1 = data
  logic            owner_q, owner_d;            // 0 = fetch, 1 = data
  logic            write_q, write_d;
  logic [63:0]     addr_q, addr_d;
  logic            err_q, err_d;

  logic             grant_f, grant_d;
  logic             last_beat;
  logic             id_mismatch;
  logic [TAG_W-1:0] req_tag;
  logic             unused_resptag;

  assign last_beat      = (beat_cnt_q == CntW'(BEATS - 1));
  assign req_tag        = TAG_W'({write_q, TypeMemory, 7'd0, owner_q});
  assign id_mismatch    = (bus_resptag[7:0] != {7'd0, owner_q});
  assign unused_resptag = ^bus_resptag[TAG_W-1:8];
  assign err_sticky     = err_q;

  // Grants are gated by reset_n so the ready pulses stay low while reset is
  // asserted, even though they are combinational from the request inputs.
  always_comb begin
    grant_f = 1'b0;
    grant_d = 1'b0;
    if (state_q == StIdle && reset_n) begin
      if (f_req_valid && d_req_valid) begin
`ifdef ARB_DATA_PRIORITY_EN
        grant_d = 1'b1;
`else
        // Round-robin: the port that did not win last time takes the tie.
        if (last_grant_q) grant_f = 1'b1;
        else              grant_d = 1'b1;
`endif
      end else begin
        grant_f = f_req_valid;
        grant_d = d_req_valid;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    write_d       = write_q;
    addr_d        = addr_q;
    err_d         = err_q;
    f_req_ready   = 1'b0;
    d_req_ready   = 1'b0;
    f_resp_valid  = 1'b0;
    f_resp_data   = '0;
    d_resp_valid  = 1'b0;
    d_resp_data   = '0;
    d_wdata_ready = 1'b0;
    bus_reqcyc    = 1'b0;
    bus_req       = '0;
    bus_reqtag    = '0;
    bus_respack   = 1'b0;

    unique case (state_q)
      StIdle: begin
        f_req_ready = grant_f;
        d_req_ready = grant_d;
        if (grant_f || grant_d) begin
          owner_d      = grant_d;
          // Fetch requests are always reads.
          write_d      = grant_d & d_req_write;
          addr_d       = (grant_d ? d_req_addr : f_req_addr) & ~64'h3F;
          last_grant_d = grant_d;
          state_d      = StReq;
        end
      end

      StReq: begin
        bus_reqcyc = 1'b1;
        bus_req    = addr_q;
        bus_reqtag = req_tag;
        if (bus_reqack) begin
          beat_cnt_d = '0;
          state_d    = write_q ? StWdata : StResp;
        end
      end

      StWdata: begin
        bus_reqcyc    = d_wdata_valid;
        bus_req       = d_wdata;
        bus_reqtag    = req_tag;
        d_wdata_ready = bus_reqack & d_wdata_valid;
        if (d_wdata_ready) begin
          beat_cnt_d = beat_cnt_q + CntW'(1);
          if (last_beat) state_d = StIdle;
        end
      end

      StResp: begin
        bus_respack = bus_respcyc;
        if (owner_q) begin
          d_resp_valid = bus_respcyc;
          d_resp_data  = bus_resp;
        end else begin
          f_resp_valid = bus_respcyc;
          f_resp_data  = bus_resp;
        end
        if (bus_respcyc) begin
          // A mis-tagged beat is still delivered to the owner and counted.
          if (id_mismatch) err_d = 1'b1;
          beat_cnt_d = beat_cnt_q + CntW'(1);
          if (last_beat) state_d = StIdle;
        end
      end
    endcase

    // A response beat with no read outstanding is never acked.
    if (bus_respcyc && state_q != StResp) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      beat_cnt_q   <= '0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_sysbus_arbiter.sv
module tb_sysbus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        f_req_valid, f_req_ready, f_resp_valid;
  logic [63:0] f_req_addr, f_resp_data;
  logic        d_req_valid, d_req_write, d_req_ready;
  logic [63:0] d_req_addr, d_wdata, d_resp_data;
  logic        d_wdata_valid, d_wdata_ready, d_resp_valid;
  logic        bus_reqcyc, bus_reqack, bus_respcyc, bus_respack, err_sticky;
  logic [63:0] bus_req, bus_resp;
  logic [12:0] bus_reqtag, bus_resptag;

  sysbus_arbiter #(.BEATS(8), .TAG_W(13)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .f_req_valid  (f_req_valid),
    .f_req_addr   (f_req_addr),
    .f_req_ready  (f_req_ready),
    .f_resp_valid (f_resp_valid),
    .f_resp_data  (f_resp_data),
    .d_req_valid  (d_req_valid),
    .d_req_write  (d_req_write),
    .d_req_addr   (d_req_addr),
    .d_req_ready  (d_req_ready),
    .d_wdata      (d_wdata),
    .d_wdata_valid(d_wdata_valid),
    .d_wdata_ready(d_wdata_ready),
    .d_resp_valid (d_resp_valid),
    .d_resp_data  (d_resp_data),
    .bus_reqcyc   (bus_reqcyc),
    .bus_req      (bus_req),
    .bus_reqtag   (bus_reqtag),
    .bus_reqack   (bus_reqack),
    .bus_respcyc  (bus_respcyc),
    .bus_resp     (bus_resp),
    .bus_resptag  (bus_resptag),
    .bus_respack  (bus_respack),
    .err_sticky   (err_sticky)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] q_f[$];
  logic [63:0] q_d[$];
  logic [63:0] q_w[$];
  int f_beats = 0;
  int d_beats = 0;
  int w_beats = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every beat the DUT hands out must match the next queued one.
  always @(negedge clk) begin
    if (f_resp_valid) begin
      f_beats++;
      check_eq("f_resp_expected", 64'(q_f.size() > 0), 64'd1);
      if (q_f.size() > 0) check_eq("f_resp_data", f_resp_data, q_f.pop_front());
    end
    if (d_resp_valid) begin
      d_beats++;
      check_eq("d_resp_expected", 64'(q_d.size() > 0), 64'd1);
      if (q_d.size() > 0) check_eq("d_resp_data", d_resp_data, q_d.pop_front());
    end
    if (d_wdata_ready) begin
      w_beats++;
      check_eq("wbeat_expected", 64'(q_w.size() > 0), 64'd1);
      if (q_w.size() > 0) check_eq("wbeat_data", bus_req, q_w.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input int p, input logic wr, input logic [63:0] a);
    if (p == 0) begin
      f_req_valid = 1'b1;
      f_req_addr  = a;
    end else begin
      d_req_valid = 1'b1;
      d_req_write = wr;
      d_req_addr  = a;
    end
    @(negedge clk);
    check_eq("f_req_ready", 64'(f_req_ready), 64'(p == 0));
    check_eq("d_req_ready", 64'(d_req_ready), 64'(p == 1));
    tick();
    f_req_valid = 1'b0;
    d_req_valid = 1'b0;
  endtask

  task automatic accept(input logic [63:0] ea, input logic [12:0] et, input int delay);
    for (int i = 0; i <= delay; i++) begin
      bus_reqack = (i == delay);
      @(negedge clk);
      check_eq("reqcyc", 64'(bus_reqcyc), 64'd1);
      check_eq("req_addr", bus_req, ea);
      check_eq("reqtag", 64'(bus_reqtag), 64'(et));
      tick();
    end
    bus_reqack = 1'b0;
  endtask

  task automatic beats(input int p, input int n, input logic [12:0] tag, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      bus_respcyc = 1'b1;
      bus_resp    = base + 64'h11 * (i + 1);
      bus_resptag = tag;
      if (p == 0) q_f.push_back(bus_resp);
      else        q_d.push_back(bus_resp);
      @(negedge clk);
      check_eq("respack", 64'(bus_respack), 64'd1);
      check_eq("ready_busy", 64'(f_req_ready | d_req_ready), 64'd0);
      tick();
    end
    bus_respcyc = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fb;
    int db;
    int sent;
    int c;
    bit first_d;
    reset_n = 1'b0;
    f_req_valid = 1'b1; f_req_addr = 64'h0;
    d_req_valid = 1'b1; d_req_write = 1'b0; d_req_addr = 64'h0;
    d_wdata = '0; d_wdata_valid = 1'b0;
    bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
    #3;
    check_eq("rst_f_ready", 64'(f_req_ready), 64'd0);
    check_eq("rst_d_ready", 64'(d_req_ready), 64'd0);
    check_eq("rst_reqcyc", 64'(bus_reqcyc), 64'd0);
    check_eq("rst_err", 64'(err_sticky), 64'd0);
    tick();
    tick();
    f_req_valid = 1'b0;
    d_req_valid = 1'b0;
    reset_n = 1'b1;
    tick();

    // Tie right after reset.
`ifdef ARB_DATA_PRIORITY_EN
    first_d = 1'b1;
`else
    first_d = 1'b0;
`endif
    f_req_valid = 1'b1; f_req_addr = 64'h3000;
    d_req_valid = 1'b1; d_req_write = 1'b0; d_req_addr = 64'h4000;
    @(negedge clk);
    check_eq("tie1_f_ready", 64'(f_req_ready), 64'(!first_d));
    check_eq("tie1_d_ready", 64'(d_req_ready), 64'(first_d));
    tick();
    if (first_d) begin
      d_req_valid = 1'b0;
      accept(64'h4000, 13'h0101, 0);
      beats(1, 8, 13'h0101, 64'h400);
    end else begin
      f_req_valid = 1'b0;
      accept(64'h3000, 13'h0100, 0);
      beats(0, 8, 13'h0100, 64'h300);
    end
    @(negedge clk);
    check_eq("tie2_f_ready", 64'(f_req_ready), 64'(first_d));
    check_eq("tie2_d_ready", 64'(d_req_ready), 64'(!first_d));
    tick();
    f_req_valid = 1'b0;
    d_req_valid = 1'b0;
    if (first_d) begin
      accept(64'h3000, 13'h0100, 0);
      beats(0, 8, 13'h0100, 64'h300);
    end else begin
      accept(64'h4000, 13'h0101, 0);
      beats(1, 8, 13'h0101, 64'h400);
    end

    // Fetch-only read.
    fb = f_beats;
    request(0, 1'b0, 64'h1000_0047);
    accept(64'h1000_0040, 13'h0100, 2);
    beats(0, 8, 13'h0100, 64'h0);
    check_eq("fetch_beats", 64'(f_beats - fb), 64'd8);
    check_eq("fetch_q_empty", 64'(q_f.size()), 64'd0);
    check_eq("fetch_err", 64'(err_sticky), 64'd0);

    // Data write with toggling beat valid.
    fb = f_beats;
    db = d_beats;
    request(1, 1'b1, 64'h2000);
    accept(64'h2000, 13'h1101, 0);
    bus_reqack = 1'b1;
    sent = 0;
    c = 0;
    while (sent < 8 && c < 40) begin
      d_wdata_valid = (c % 2 == 0);
      d_wdata = 64'hA000 + 64'(c);
      if (d_wdata_valid) begin
        q_w.push_back(d_wdata);
        sent++;
      end
      @(negedge clk);
      check_eq("wr_reqcyc", 64'(bus_reqcyc), 64'(d_wdata_valid));
      tick();
      c++;
    end
    d_wdata_valid = 1'b1;
    d_wdata = 64'hDEAD;
    @(negedge clk);
    check_eq("wr_done_ready", 64'(d_wdata_ready), 64'd0);
    tick();
    d_wdata_valid = 1'b0;
    bus_reqack = 1'b0;
    check_eq("wr_beats", 64'(w_beats), 64'd8);
    check_eq("wr_no_resp", 64'((f_beats - fb) + (d_beats - db)), 64'd0);

    // Stray response while idle.
    bus_respcyc = 1'b1;
    bus_resptag = 13'h0100;
    @(negedge clk);
    check_eq("stray_respack", 64'(bus_respack), 64'd0);
    tick();
    bus_respcyc = 1'b0;
    check_eq("stray_err", 64'(err_sticky), 64'd1);
    repeat (3) tick();
    check_eq("stray_err_hold", 64'(err_sticky), 64'd1);

    // Reset in the middle of a read.
    request(0, 1'b0, 64'h5000);
    accept(64'h5000, 13'h0100, 1);
    beats(0, 3, 13'h0100, 64'h500);
    reset_n = 1'b0;
    bus_respcyc = 1'b1;
    f_req_valid = 1'b1;
    #1;
    check_eq("midrst_f_resp", 64'(f_resp_valid), 64'd0);
    check_eq("midrst_respack", 64'(bus_respack), 64'd0);
    check_eq("midrst_f_ready", 64'(f_req_ready), 64'd0);
    check_eq("midrst_err", 64'(err_sticky), 64'd0);
    tick();
    bus_respcyc = 1'b0;
    f_req_valid = 1'b0;
    reset_n = 1'b1;
    tick();
    fb = f_beats;
    request(0, 1'b0, 64'h5008);
    accept(64'h5000, 13'h0100, 0);
    beats(0, 8, 13'h0100, 64'h600);
    check_eq("post_rst_beats", 64'(f_beats - fb), 64'd8);
    check_eq("post_rst_err", 64'(err_sticky), 64'd0);

    // Mis-tagged response to a fetch read.
    fb = f_beats;
    request(0, 1'b0, 64'h6000);
    accept(64'h6000, 13'h0100, 0);
    beats(0, 8, 13'h0101, 64'h700);
    check_eq("tagmm_beats", 64'(f_beats - fb), 64'd8);
    check_eq("tagmm_err", 64'(err_sticky), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
